// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// the segment bit map, the hex glyph table and a counter-width helper.
package seg7_pkg;

  // Cathode bit positions on seg_n (and on active-high segment vectors).
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high gfedcba glyphs for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for the current nibble.
  always_comb begin
    seg_o = HEX_SEG[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner with anti-ghost blanking, per-digit
// enable/decimal point, raw-segment mode and frame-synchronous
// double-buffered updates (staging bank -> active bank at frame end).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_valid,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  raw_mode,
  input  logic [7*N_DIGITS-1:0] raw_seg,
  output logic [7:0]            seg_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_done,
  output logic                  upd_ack
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW  = cnt_width(DIV);
  localparam int unsigned IW  = cnt_width(N_DIGITS);
  localparam int unsigned NA  = 1 << IW;
  // Display word layout: {raw_seg, raw_mode, digit_en, dp, value}
  localparam int unsigned BW  = 13 * N_DIGITS + 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_bad_ndigits
    $error("seg7_scan_driver: N_DIGITS must be within 1..16");
  end
  if (DIV < BLANK_CYCLES + 1) begin : g_bad_div
    $error("seg7_scan_driver: CLK_HZ/SCAN_HZ must exceed BLANK_CYCLES");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] stg_q, stg_d;
  logic [BW-1:0] act_q, act_d;
  logic          pend_q, pend_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          fd_q, fd_d;
  logic          ack_q, ack_d;

  logic [BW-1:0] in_word_s;
  logic          boundary_s;
  logic [3:0]    nib_a [NA];
  logic [6:0]    raw_a [NA];
  logic          dp_a  [NA];
  logic          en_a  [NA];
  logic          act_raw_mode_s;
  logic [6:0]    dec_s;

  assign in_word_s  = {raw_seg, raw_mode, digit_en, dp, value};
  assign boundary_s = (pre_q == PRE_LAST) && (idx_q == IDX_LAST);
  assign act_raw_mode_s = act_q[6*N_DIGITS];

  // Per-digit views of the active bank, padded to a power of two so the
  // digit index selects without range issues.
  for (genvar g = 0; g < NA; g++) begin : g_dig
    if (g < N_DIGITS) begin : g_real
      assign nib_a[g] = act_q[4*g +: 4];
      assign dp_a[g]  = act_q[4*N_DIGITS + g];
      assign en_a[g]  = act_q[5*N_DIGITS + g];
      assign raw_a[g] = act_q[6*N_DIGITS + 1 + 7*g +: 7];
    end else begin : g_pad
      assign nib_a[g] = 4'h0;
      assign dp_a[g]  = 1'b0;
      assign en_a[g]  = 1'b0;
      assign raw_a[g] = 7'h00;
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble_i (nib_a[idx_q]),
    .seg_o    (dec_s)
  );

  // Slot prescaler and digit index; the last slot's last cycle is the frame boundary.
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Update handshake: writes land in staging; active changes only at the frame boundary.
  always_comb begin
    stg_d  = stg_q;
    act_d  = act_q;
    pend_d = pend_q;
    if (boundary_s) begin
      if (upd_valid) begin
        stg_d  = in_word_s;
        act_d  = in_word_s;
        pend_d = 1'b0;
      end else if (pend_q) begin
        act_d  = stg_q;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b0;
      end
    end else if (upd_valid) begin
      stg_d  = in_word_s;
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Pin values for the current slot: blanked early in the slot or when the digit is off.
  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    if (pre_q < PRE_BLANK) begin
      an_d  = '1;
      seg_d = 8'hFF;
    end else if (en_a[idx_q]) begin
      an_d = ~(N_DIGITS'(1) << idx_q);
      seg_d[SEG_G:SEG_A] = act_raw_mode_s ? ~raw_a[idx_q] : ~dec_s;
      seg_d[SEG_DP]      = ~dp_a[idx_q];
    end else begin
      an_d  = '1;
      seg_d = 8'hFF;
    end
    fd_d  = boundary_s;
    ack_d = boundary_s && (upd_valid || pend_q);
  end

  // State and output registers; reset discards any pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      idx_q  <= '0;
      stg_q  <= '0;
      act_q  <= '0;
      pend_q <= 1'b0;
      an_q   <= '1;
      seg_q  <= 8'hFF;
      fd_q   <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      stg_q  <= stg_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      fd_q   <= fd_d;
      ack_q  <= ack_d;
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign frame_done = fd_q;
  assign upd_ack    = ack_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (N_DIGITS=4, DIV=10, BLANK=2).
// A slot/frame reference model derived from the cycle count since reset
// predicts every output each cycle; table vectors and hand sequences add
// explicit checks of the documented corner cases.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int DIV   = 10;
  localparam int BLANK = 2;
  localparam int FRAME = DIV * ND;

  localparam logic [6:0] HEX_REF [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [3:0]  en;
    logic        raw;
    logic [27:0] rs;
  } disp_t;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [3:0]  en;
    logic        raw;
    logic [27:0] rs;
    logic [7:0]  seg [4];
    logic [3:0]  an  [4];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        raw_mode;
  logic [27:0] raw_seg;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;
  logic        upd_ack;

  int checks = 0;
  int errors = 0;
  int m_t    = 0;
  int dut_acks = 0;
  int dut_fds  = 0;
  disp_t m_act = '0;
  disp_t m_stg = '0;
  bit    m_pend = 1'b0;
  vec_t  vecs [3];

  seg7_scan_driver #(
    .N_DIGITS     (ND),
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .value      (value),
    .dp         (dp),
    .digit_en   (digit_en),
    .raw_mode   (raw_mode),
    .raw_seg    (raw_seg),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done),
    .upd_ack    (upd_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, m_t);
    end
  endtask

  task automatic model_reset();
    m_t    = 0;
    m_act  = '0;
    m_stg  = '0;
    m_pend = 1'b0;
  endtask

  // One clock: predict from the pre-edge state, advance the model, compare after the edge.
  task automatic tick();
    int pre;
    int dig;
    bit bnd;
    logic [6:0] s7;
    logic [3:0] ea;
    logic [7:0] es;
    logic ef;
    logic eack;
    disp_t cur;
    pre = m_t % DIV;
    dig = (m_t / DIV) % ND;
    bnd = (m_t % FRAME) == FRAME - 1;
    ea = 4'hF;
    es = 8'hFF;
    if (pre >= BLANK && m_act.en[dig]) begin
      ea[dig] = 1'b0;
      s7 = m_act.raw ? m_act.rs[dig*7 +: 7] : HEX_REF[m_act.val[dig*4 +: 4]];
      es = ~{m_act.dpv[dig], s7};
    end
    ef   = bnd;
    eack = bnd && (upd_valid || m_pend);
    cur  = '{val: value, dpv: dp, en: digit_en, raw: raw_mode, rs: raw_seg};
    if (bnd && upd_valid) begin
      m_act = cur; m_stg = cur; m_pend = 1'b0;
    end else if (bnd && m_pend) begin
      m_act = m_stg; m_pend = 1'b0;
    end else if (upd_valid) begin
      m_stg = cur; m_pend = 1'b1;
    end
    m_t++;
    @(posedge clk);
    #1;
    chk("an_n", 32'(an_n), 32'(ea));
    chk("seg_n", 32'(seg_n), 32'(es));
    chk("frame_done", 32'(frame_done), 32'(ef));
    chk("upd_ack", 32'(upd_ack), 32'(eack));
    if (upd_ack) dut_acks++;
    if (frame_done) dut_fds++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"},  32'(an_n),       32'h0000_000F);
    chk({tag, "_seg"}, 32'(seg_n),      32'h0000_00FF);
    chk({tag, "_fd"},  32'(frame_done), 32'h0);
    chk({tag, "_ack"}, 32'(upd_ack),    32'h0);
  endtask

  initial begin
    int a0;
    vecs[0].val = 16'hA810; vecs[0].dpv = 4'b0001; vecs[0].en = 4'hF; vecs[0].raw = 1'b0; vecs[0].rs = '0;
    vecs[0].seg = '{8'h40, 8'hF9, 8'h80, 8'h88};
    vecs[0].an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    vecs[1].val = 16'h0000; vecs[1].dpv = 4'b0000; vecs[1].en = 4'b0010; vecs[1].raw = 1'b1;
    vecs[1].rs  = {7'h7F, 7'h7F, 7'h49, 7'h7F};
    vecs[1].seg = '{8'hFF, 8'hB6, 8'hFF, 8'hFF};
    vecs[1].an  = '{4'hF, 4'hD, 4'hF, 4'hF};
    vecs[2].val = 16'h5E3B; vecs[2].dpv = 4'b1010; vecs[2].en = 4'b1011; vecs[2].raw = 1'b0; vecs[2].rs = '0;
    vecs[2].seg = '{8'h83, 8'h30, 8'hFF, 8'h12};
    vecs[2].an  = '{4'hE, 4'hD, 4'hF, 4'h7};

    rst_n = 1'b0; upd_valid = 1'b0; value = '0; dp = '0;
    digit_en = '0; raw_mode = 1'b0; raw_seg = '0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // No update yet: display dark, frame_done every FRAME cycles.
    repeat (3 * FRAME) tick();
    chk("idle_fd_count", 32'(dut_fds), 32'd3);
    chk("idle_ack_count", 32'(dut_acks), 32'd0);

    // Table vectors: write mid-frame, expect one ack, then probe each slot.
    for (int v = 0; v < 3; v++) begin
      while (m_t % FRAME != 13) tick();
      value = vecs[v].val; dp = vecs[v].dpv; digit_en = vecs[v].en;
      raw_mode = vecs[v].raw; raw_seg = vecs[v].rs;
      upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
      a0 = dut_acks;
      while (m_t % FRAME != 0) tick();
      chk("tbl_ack", 32'(dut_acks - a0), 32'd1);
      for (int k = 0; k < ND; k++) begin
        repeat (6) tick();
        chk("tbl_seg", 32'(seg_n), 32'(vecs[v].seg[k]));
        chk("tbl_an", 32'(an_n), 32'(vecs[v].an[k]));
        repeat (4) tick();
      end
    end

    // Two writes in one frame: last wins, single ack, old data until boundary.
    while (m_t % FRAME != 5) tick();
    value = 16'h1111; dp = '0; digit_en = 4'hF; raw_mode = 1'b0; raw_seg = '0;
    upd_valid = 1'b1; tick(); upd_valid = 1'b0;
    repeat (7) tick();
    value = 16'h2222;
    upd_valid = 1'b1; tick(); upd_valid = 1'b0;
    a0 = dut_acks;
    while (m_t % FRAME != 0) tick();
    repeat (2 * DIV + 6) tick();
    chk("dbl_seg_digit2", 32'(seg_n), 32'h0000_00A4);
    repeat (2 * DIV - 6) tick();
    chk("dbl_ack_count", 32'(dut_acks - a0), 32'd1);

    // Write on the exact boundary cycle: ack with frame_done, visible in first slot.
    while (m_t % FRAME != FRAME - 1) tick();
    value = 16'h0F96;
    upd_valid = 1'b1; tick(); upd_valid = 1'b0;
    chk("bnd_ack", 32'(upd_ack), 32'h1);
    chk("bnd_fd", 32'(frame_done), 32'h1);
    repeat (6) tick();
    chk("bnd_seg_digit0", 32'(seg_n), 32'h0000_0082);
    chk("bnd_an_digit0", 32'(an_n), 32'h0000_000E);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom); dp = 4'($urandom); digit_en = 4'($urandom);
        raw_mode = 1'($urandom); raw_seg = 28'($urandom);
        upd_valid = 1'b1;
      end
      tick();
      upd_valid = 1'b0;
    end

    // Reset mid-slot with an update pending: it must be discarded.
    while (m_t % FRAME != 5) tick();
    value = 16'h8888; dp = 4'hF; digit_en = 4'hF; raw_mode = 1'b0;
    upd_valid = 1'b1; tick(); upd_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    model_reset();
    a0 = dut_acks;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME + 20) tick();
    chk("midrst_ack_count", 32'(dut_acks - a0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver for the board-level top, the successor of the fixed 8-digit seg_n/an_n scanner. It adds:
- configurable digit count and scan rate;
- an anti-ghosting blanking window;
- per-digit enable and decimal point;
- a raw-segment mode;
- double-buffered, frame-synchronous display updates with a handshake.

The CPU/debug logic writes display words, and this block owns the physical seg_n/an_n pins.

Parameters:
N_DIGITS, 8, number of digits scanned; legal range 1..16
CLK_HZ, 100_000_000, input clock frequency
SCAN_HZ, 1000, digit-slot rate; each slot lasts DIV = CLK_HZ/SCAN_HZ cycles
BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off; elaboration error unless DIV >= BLANK_CYCLES+1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
upd_valid  in  1  one-cycle strobe; samples value/dp/digit_en/raw_mode/raw_seg into staging
value  in  4*N_DIGITS  hex nibble per digit; digit 0 = bits [3:0]
dp  in  N_DIGITS  decimal point on, per digit, active-high
digit_en  in  N_DIGITS  digit enabled; a disabled digit keeps its anode off for its whole slot
raw_mode  in  1  1 = use raw_seg instead of the hex decode
raw_seg  in  7*N_DIGITS  raw segments per digit, active-high, bit0 = a .. bit6 = g
seg_n  out  8  cathodes, active-low; bit0 = a .. bit6 = g, bit7 = dp
an_n  out  N_DIGITS  anodes, active-low; digit i = bit i
frame_done  out  1  one-cycle pulse at the end of each full scan frame
upd_ack  out  1  one-cycle pulse when staged data becomes active

Behaviour:
- Reset (async assert, clean release on the next clk edge): prescaler=0, digit index=0, staging and active registers all zero, pending=0. Outputs: an_n all 1, seg_n=8'hFF, frame_done=0, upd_ack=0.
- Prescaler counts 0..DIV-1. At DIV-1 it wraps to 0 and the digit index increments. The index wraps N_DIGITS-1 -> 0; that wrap cycle is the frame boundary.
- Outputs are registered and reflect the prescaler/index state of the previous cycle (1-cycle latency).
- Blanking: while prescaler < BLANK_CYCLES, an_n = all 1 and seg_n = 8'hFF.
- Otherwise, for digit k:
  - an_n has only bit k low if active digit_en[k]=1; all 1 if digit_en[k]=0.
  - seg_n[6:0] = ~decode(active nibble k) in hex mode, or ~raw_seg[k] in raw mode.
  - seg_n[7] = ~dp[k].
  - If digit k is disabled, seg_n = 8'hFF.
- Hex decode (active-high gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Update handshake:
  - upd_valid copies all data inputs into staging and sets pending.
  - Repeated upd_valid within a frame overwrites staging; last write wins.
  - At the frame boundary, if pending: active <= staging, pending <= 0, and upd_ack pulses in the same cycle as frame_done.
  - Active contents never change mid-frame, so there is no tearing.
- upd_valid coincident with the frame boundary: the current inputs load directly into both active and staging, pending <= 0, upd_ack pulses.
- frame_done pulses every frame, whether or not an update occurred.
- Reset mid-frame: everything returns to reset values immediately and pending updates are discarded.
- N_DIGITS=1: every slot is a frame boundary, so frame_done pulses once per DIV cycles.

Decomposition:
- Package seg7_pkg:
  - hex-to-segment constant table (16 x 7 bits);
  - segment bit index constants (SEG_A..SEG_G, SEG_DP);
  - localparam helper for clog2-based DIV and index widths.
- Sub-module seg7_hex_decode: combinational 4-bit to 7-bit active-high, instantiated once on the muxed current nibble.
- Top owns the prescaler, digit counter, staging/active banks and output registers.

Test Plan:
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (DIV=10), N_DIGITS=4, BLANK_CYCLES=2.
- Reset release, no update -> an_n=4'hF for all time (digit_en=0 after reset), seg_n=8'hFF; frame_done pulses every 40 cycles.
- upd_valid with value=16'hA810, dp=4'b0001, digit_en=4'hF, raw_mode=0 -> upd_ack with the next frame_done. Next frame:
  - digit0 slot: an_n=4'b1110, seg_n=8'h40 ('0' + dp) for cycles 2..9 of the slot, 4'hF/8'hFF for cycles 0..1;
  - digit1: 8'hF9;
  - digit2: 8'h80;
  - digit3: 8'h88.
- Two upd_valid mid-frame (value 16'h1111 then 16'h2222) -> the display stays on the old data until the boundary, then shows 2 (seg_n=8'hA4) on all digits; only one upd_ack.
- upd_valid on the exact frame-boundary cycle -> upd_ack the same cycle; new data visible in the first slot of the next frame.
- raw_mode=1, raw_seg digit1=7'h49, digit_en=4'b0010 -> only the digit1 slot drives an_n=4'b1101 with seg_n=8'hB6; other slots all anodes off.
- Assert rst_n low mid-slot with a pending update -> outputs go to reset values asynchronously; after release the old data never appears and upd_ack does not pulse.
